// File: rtl/byte_stream_serializer.sv
// ============================================================================
// Module   : byte_stream_serializer
// Function : Captures a wide result word (hash, nonce or status) and presents
//            it one byte at a time to the UART Tx shift register, with a
//            busy/done handshake, overrun flag, abort and last-byte marker.
//            Optional macro SERIALIZER_CHECKSUM_EN appends an XOR checksum
//            byte after the data bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_stream_serializer #(
  parameter int NUM_BYTES = 32,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = $clog2(NUM_BYTES)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load,
  input  logic [8*NUM_BYTES-1:0] load_data,
  input  logic                   abort,
  input  logic                   inc_data,
  output logic                   busy,
  output logic [7:0]             read_data,
  output logic                   last_byte,
  output logic                   done,
  output logic                   overrun
);

`ifdef SERIALIZER_CHECKSUM_EN
  // Checksum byte extends the stream by one, so the counter may need a bit more.
  localparam int STREAM_LEN = NUM_BYTES + 1;
  localparam int CHK_IDX_W  = $clog2(NUM_BYTES + 1);
  localparam int CNT_W      = (CHK_IDX_W > IDX_W) ? CHK_IDX_W : IDX_W;
`else
  localparam int STREAM_LEN = NUM_BYTES;
  localparam int CNT_W      = IDX_W;
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STREAM_LEN - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [8*NUM_BYTES-1:0] word_q, word_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0]             chk_q, chk_d;
  logic [7:0]             chk_calc;
`endif

  logic [CNT_W-1:0]       byte_sel;
  logic [7:0]             data_byte;

  // State and datapath registers; asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
      chk_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef SERIALIZER_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  // Next-state logic: accept loads in IDLE, step/abort/finish in SEND.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
    chk_d     = chk_q;
    chk_calc  = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      chk_calc = chk_calc ^ load_data[8*k +: 8];
    end
`endif
    case (state_q)
      S_IDLE: begin
        // inc_data and abort carry no meaning without a transfer in flight.
        if (load) begin
          word_d  = load_data;
          idx_d   = '0;
          state_d = S_SEND;
`ifdef SERIALIZER_CHECKSUM_EN
          chk_d   = chk_calc;
`endif
        end
      end
      default: begin
        // A load during a transfer never disturbs the word being sent.
        overrun_d = load;
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (inc_data) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Output logic: byte selection by order, zeroed whenever no transfer is active.
  always_comb begin
    busy      = (state_q == S_SEND);
    done      = done_q;
    overrun   = overrun_q;
    last_byte = busy && (idx_q == LAST_IDX);

    if (MSB_FIRST != 0) begin
      byte_sel = CNT_W'(NUM_BYTES - 1) - idx_q;
    end else begin
      byte_sel = idx_q;
    end

    data_byte = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (byte_sel == CNT_W'(k)) begin
        data_byte = word_q[8*k +: 8];
      end
    end
`ifdef SERIALIZER_CHECKSUM_EN
    if (idx_q == CNT_W'(NUM_BYTES)) begin
      data_byte = chk_q;
    end
`endif

    read_data = busy ? data_byte : 8'h00;
  end

endmodule

`default_nettype wire
